// File: rtl/alu_mdu_if.sv
// EX-stage ALU/MDU bus: operands, opcode and issue qualifier in; result, flags,
// MDU handshake and HI/LO out.
interface alu_mdu_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] a, b, imm1, imm0;
  logic [1:0]       mask;
  logic [4:0]       op;
  logic             start;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             busy, done, stall;
  logic [WIDTH-1:0] hi, lo;

  modport master (output a, b, imm1, imm0, mask, op, start,
                  input  result, flags, busy, done, stall, hi, lo);
  modport slave  (input  a, b, imm1, imm0, mask, op, start,
                  output result, flags, busy, done, stall, hi, lo);
endinterface

// File: rtl/alu_mdu.sv
// Combinational EX ALU plus iterative multiply/divide unit with HI/LO registers.
// Define ALU_MDU_MADD_EN to add MADD/MSUB (signed multiply-accumulate into HI/LO).
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic   clk,
  input  logic   rst,
  alu_mdu_if.slave bus
);
  localparam int SH_W = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_SLL  = 5'd2,  OP_SRL  = 5'd3;
  localparam logic [4:0] OP_SRA  = 5'd4,  OP_AND  = 5'd5,  OP_OR   = 5'd6,  OP_XOR  = 5'd7;
  localparam logic [4:0] OP_NOR  = 5'd8,  OP_SLTU = 5'd9,  OP_SLT  = 5'd10, OP_ADDM4 = 5'd11;
  localparam logic [4:0] OP_MFHI = 5'd12, OP_MFLO = 5'd13, OP_MTHI = 5'd14, OP_MTLO = 5'd15;
  localparam logic [4:0] OP_MULT = 5'd16, OP_MULTU = 5'd17, OP_DIV = 5'd18, OP_DIVU = 5'd19;
`ifdef ALU_MDU_MADD_EN
  localparam logic [4:0] OP_MADD = 5'd20, OP_MSUB = 5'd21;
`endif
  localparam logic [WIDTH:0] FOUR = {{(WIDTH-2){1'b0}}, 3'b100};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [SH_W-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
  logic [4:0]         mop_q, mop_d;
  logic               neg_q, neg_d, dneg_q, dneg_d, dz_q, dz_d, done_q;
  logic               busy, go, is_mdu, is_signed, is_div, div_q;

  logic [WIDTH-1:0]   op_a, op_b, sra_b, mag_a, mag_b;
  logic [SH_W-1:0]    sh;
  logic [WIDTH:0]     sa, sb, c;
  logic               sign_a, sign_b;

  function automatic logic [WIDTH:0] sx(input logic [WIDTH-1:0] v);
    return {v[WIDTH-1], v};
  endfunction

  assign op_a  = bus.mask[1] ? bus.imm1 : bus.a;
  assign op_b  = bus.mask[0] ? bus.imm0 : bus.b;
  assign sa    = sx(op_a);
  assign sb    = sx(op_b);
  assign sh    = op_a[SH_W-1:0];
  assign sra_b = $unsigned($signed(op_b) >>> sh);

  always_comb begin
    c = '0;
    case (bus.op)
      OP_ADD:   c = sa + sb;
      OP_SUB:   c = sa - sb;
      OP_SLL:   c = sx(op_b << sh);
      OP_SRL:   c = sx(op_b >> sh);
      OP_SRA:   c = sx(sra_b);
      OP_AND:   c = sa & sb;
      OP_OR:    c = sa | sb;
      OP_XOR:   c = sa ^ sb;
      OP_NOR:   c = ~(sa | sb);
      OP_SLTU:  c = {{WIDTH{1'b0}}, (op_a < op_b)};
      OP_SLT:   c = {{WIDTH{1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_ADDM4: c = sa + sb - FOUR;
      OP_MFHI:  c = sx(hi_q);
      OP_MFLO:  c = sx(lo_q);
      OP_MTHI, OP_MTLO: c = sa;
      default:  c = '0;
    endcase
  end

  assign bus.result = c[WIDTH-1:0];
  assign bus.flags  = {c[WIDTH-1], ~|c[WIDTH-1:0],
                       (c[WIDTH:WIDTH-1] == 2'b01), (c[WIDTH:WIDTH-1] == 2'b10)};

  always_comb begin
    is_mdu    = 1'b0;
    is_signed = 1'b0;
    case (bus.op)
      OP_MULT, OP_DIV: begin is_mdu = 1'b1; is_signed = 1'b1; end
      OP_MULTU, OP_DIVU: is_mdu = 1'b1;
`ifdef ALU_MDU_MADD_EN
      OP_MADD, OP_MSUB: begin is_mdu = 1'b1; is_signed = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign is_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
  assign div_q     = (mop_q == OP_DIV) || (mop_q == OP_DIVU);
  assign go        = bus.start & ~busy & is_mdu;
  assign sign_a    = is_signed & op_a[WIDTH-1];
  assign sign_b    = is_signed & op_b[WIDTH-1];
  assign mag_a     = sign_a ? -op_a : op_a;
  assign mag_b     = sign_b ? -op_b : op_b;
  assign bus.stall = busy & bus.start & (bus.op >= OP_MFHI) & (bus.op <= 5'd21);

  // FSM: state register / next state / outputs
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go) state_d = S_RUN;
      S_RUN:   if (&cnt_q) state_d = S_FIX;   // WIDTH is a power of two: last step is all ones
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
  end

  logic [WIDTH:0]     shifted, diff, sum;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    mop_d   = mop_q;
    neg_d   = neg_q;
    dneg_d  = dneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    shifted = '0;
    diff    = '0;
    sum     = '0;
    prod    = '0;
    case (state_q)
      S_IDLE: if (go) begin
        mop_d  = bus.op;
        neg_d  = sign_a ^ sign_b;
        dneg_d = sign_a;
        dz_d   = (op_b == '0);
        cnt_d  = '0;
        opnd_d = is_div ? mag_b : mag_a;
        acc_d  = {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
      end
      S_RUN: begin
        cnt_d = cnt_q + {{(SH_W-1){1'b0}}, 1'b1};
        if (div_q) begin
          // restoring step: remainder in the upper half, quotient shifts in below
          shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
          diff    = shifted - {1'b0, opnd_q};
          if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else              acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
          acc_d = {sum, acc_q[WIDTH-1:1]};
        end
      end
      S_FIX: begin
        if (div_q) begin
          // divide by zero leaves |dividend| as remainder; sign fix restores it as issued
          hi_d = dneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          lo_d = dz_q ? '1 : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
        end else begin
          prod = neg_q ? -acc_q : acc_q;
`ifdef ALU_MDU_MADD_EN
          if (mop_q == OP_MADD)      {hi_d, lo_d} = {hi_q, lo_q} + prod;
          else if (mop_q == OP_MSUB) {hi_d, lo_d} = {hi_q, lo_q} - prod;
          else                       {hi_d, lo_d} = prod;
`else
          {hi_d, lo_d} = prod;
`endif
        end
      end
      default: ;
    endcase
    if (bus.start && !busy) begin
      if (bus.op == OP_MTHI) hi_d = op_a;
      if (bus.op == OP_MTLO) lo_d = op_a;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= (state_q == S_FIX);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q  <= cnt_d;
    acc_q  <= acc_d;
    opnd_q <= opnd_d;
    mop_q  <= mop_d;
    neg_q  <= neg_d;
    dneg_q <= dneg_d;
    dz_q   <= dz_d;
  end

  assign bus.busy = busy;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
